// File: rtl/facto_pkg.sv
// facto_pkg: shared definitions for the factorial accelerator bus master.
// Holds slave register indices, the address helper and the master FSM states.
package facto_pkg;

   localparam logic [2:0] OP_START = 3'd0;
   localparam logic [2:0] OP_CLEAR = 3'd1;
   localparam logic [2:0] OP_DONE  = 3'd2;
   localparam logic [2:0] INTR_EN  = 3'd3;
   localparam logic [2:0] OPERAND  = 3'd4;
   localparam logic [2:0] RESULT_H = 3'd5;
   localparam logic [2:0] RESULT_L = 3'd6;

   typedef enum logic [3:0] {
      IDLE,
      WR_OPND,
      WR_IEN,
      WR_START,
      WAIT,
      POLL,
      RD_H,
      RD_L,
      WR_CLR1,
      WR_CLR0,
      RESP
   } facto_master_state_t;

   // Byte offset of register idx; registers sit on 8-byte strides.
   function automatic logic [15:0] addr_of(input logic [2:0] idx);
      return {10'd0, idx, 3'd0};
   endfunction

endpackage

// File: rtl/facto_bus_drv.sv
// facto_bus_drv: turns a registered one-cycle command into slave bus signals.
// Ports: cmd_*_i command in; m_sel/m_wr/m_addr/m_dout bus out; rd_stb_o read strobe.
module facto_bus_drv
   import facto_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        cmd_vld_i,
   input  logic        cmd_wr_i,
   input  logic [2:0]  cmd_idx_i,
   input  logic [63:0] cmd_data_i,
   output logic        m_sel,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [63:0] m_dout,
   output logic        rd_stb_o
);

   // Everything is gated so the bus reads all-zero between accesses.
   assign m_sel    = cmd_vld_i;
   assign m_wr     = cmd_vld_i & cmd_wr_i;
   assign m_addr   = cmd_vld_i ? (BASE_ADDR + addr_of(cmd_idx_i)) : 16'd0;
   assign m_dout   = (cmd_vld_i & cmd_wr_i) ? cmd_data_i : 64'd0;
   assign rd_stb_o = cmd_vld_i & ~cmd_wr_i;

endmodule

// File: rtl/facto_master.sv
// facto_master: programs one factorial slave, waits for done, returns 128-bit n!.
// Ports: req_* operand in, res_* result out, busy, m_* slave bus, irq.
// Optional macro FACTO_MASTER_IRQ_EN: irq-driven completion instead of polling.
module facto_master
   import facto_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          POLL_GAP  = 4,
   parameter int          TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_operand,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_h,
   output logic [63:0] res_l,
   output logic        res_err,
   output logic        busy,
   output logic        m_sel,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [63:0] m_dout,
   input  logic [63:0] m_din,
   input  logic        irq
);

   localparam int          GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   facto_master_state_t state_q, state_d;
   logic [31:0]   timer_q, timer_d, timer_inc;
   logic [GW-1:0] gap_q, gap_d;
   logic [63:0]   opnd_q, opnd_d;
   logic [63:0]   res_h_q, res_h_d;
   logic [63:0]   res_l_q, res_l_d;
   logic          err_q, err_d;
   logic          cmd_vld_q, cmd_vld_d;
   logic          cmd_wr_q, cmd_wr_d;
   logic [2:0]    cmd_idx_q, cmd_idx_d;
   logic [63:0]   cmd_data_q, cmd_data_d;
   logic          rd_stb;
   logic          tmo;

   // Saturating timer: once at all-ones it stays there.
   assign timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
   assign tmo       = (timer_q >= TMO_LAST);

`ifndef FACTO_MASTER_IRQ_EN
   logic unused_irq;
   assign unused_irq = irq;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      opnd_d  = opnd_q;
      res_h_d = res_h_q;
      res_l_d = res_l_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               opnd_d  = req_operand;
               timer_d = 32'd0;
               res_h_d = 64'd0;
               res_l_d = 64'd0;
               err_d   = 1'b0;
               state_d = WR_OPND;
            end
         end
`ifdef FACTO_MASTER_IRQ_EN
         WR_OPND: state_d = WR_IEN;
`else
         WR_OPND: state_d = WR_START;
`endif
         WR_IEN:  state_d = WR_START;
         WR_START: begin
            timer_d = 32'd0;
            gap_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_inc;
            gap_d   = gap_q + 1'b1;
`ifdef FACTO_MASTER_IRQ_EN
            if (irq) begin
               state_d = RD_H;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = WR_CLR1;
            end
`else
            if (tmo) begin
               err_d   = 1'b1;
               state_d = WR_CLR1;
            end else if (gap_q == GAP_LAST) begin
               state_d = POLL;
            end
`endif
         end
         POLL: begin
            timer_d = timer_inc;
            gap_d   = '0;
            state_d = (rd_stb && m_din[0]) ? RD_H : WAIT;
         end
         RD_H: begin
            if (rd_stb) res_h_d = m_din;
            state_d = RD_L;
         end
         RD_L: begin
            if (rd_stb) res_l_d = m_din;
            state_d = WR_CLR1;
         end
         WR_CLR1: state_d = WR_CLR0;
         WR_CLR0: state_d = RESP;
         RESP: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus command is decoded from the next state and registered, so the
   // access lands exactly in the cycle the FSM sits in that state.
   always_comb begin
      cmd_vld_d  = 1'b0;
      cmd_wr_d   = 1'b0;
      cmd_idx_d  = 3'd0;
      cmd_data_d = 64'd0;
      unique case (state_d)
         WR_OPND: begin
            cmd_vld_d  = 1'b1;
            cmd_wr_d   = 1'b1;
            cmd_idx_d  = OPERAND;
            cmd_data_d = opnd_d;
         end
         WR_IEN: begin
            cmd_vld_d  = 1'b1;
            cmd_wr_d   = 1'b1;
            cmd_idx_d  = INTR_EN;
            cmd_data_d = 64'd1;
         end
         WR_START: begin
            cmd_vld_d  = 1'b1;
            cmd_wr_d   = 1'b1;
            cmd_idx_d  = OP_START;
            cmd_data_d = 64'd1;
         end
         POLL: begin
            cmd_vld_d = 1'b1;
            cmd_idx_d = OP_DONE;
         end
         RD_H: begin
            cmd_vld_d = 1'b1;
            cmd_idx_d = RESULT_H;
         end
         RD_L: begin
            cmd_vld_d = 1'b1;
            cmd_idx_d = RESULT_L;
         end
         WR_CLR1: begin
            cmd_vld_d  = 1'b1;
            cmd_wr_d   = 1'b1;
            cmd_idx_d  = OP_CLEAR;
            cmd_data_d = 64'd1;
         end
         WR_CLR0: begin
            cmd_vld_d = 1'b1;
            cmd_wr_d  = 1'b1;
            cmd_idx_d = OP_CLEAR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         timer_q    <= 32'd0;
         gap_q      <= '0;
         opnd_q     <= 64'd0;
         res_h_q    <= 64'd0;
         res_l_q    <= 64'd0;
         err_q      <= 1'b0;
         cmd_vld_q  <= 1'b0;
         cmd_wr_q   <= 1'b0;
         cmd_idx_q  <= 3'd0;
         cmd_data_q <= 64'd0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         gap_q      <= gap_d;
         opnd_q     <= opnd_d;
         res_h_q    <= res_h_d;
         res_l_q    <= res_l_d;
         err_q      <= err_d;
         cmd_vld_q  <= cmd_vld_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_idx_q  <= cmd_idx_d;
         cmd_data_q <= cmd_data_d;
      end
   end

   facto_bus_drv #(
      .BASE_ADDR(BASE_ADDR)
   ) u_bus (
      .cmd_vld_i (cmd_vld_q),
      .cmd_wr_i  (cmd_wr_q),
      .cmd_idx_i (cmd_idx_q),
      .cmd_data_i(cmd_data_q),
      .m_sel     (m_sel),
      .m_wr      (m_wr),
      .m_addr    (m_addr),
      .m_dout    (m_dout),
      .rd_stb_o  (rd_stb)
   );

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == RESP);
   assign res_h     = res_h_q;
   assign res_l     = res_l_q;
   assign res_err   = err_q;

endmodule

// File: tb/tb_facto_master.sv
// tb_facto_master: directed bench for facto_master with a cycle-exact slave model.
// Optional macro FACTO_MASTER_IRQ_EN selects the irq-completion expectations.
module tb_facto_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_operand = 64'd0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [63:0] res_h;
   logic [63:0] res_l;
   logic        res_err;
   logic        busy;
   logic        m_sel;
   logic        m_wr;
   logic [15:0] m_addr;
   logic [63:0] m_dout;
   logic [63:0] m_din;
   logic        irq;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   facto_master #(
      .BASE_ADDR(16'h0000),
      .POLL_GAP (4),
      .TIMEOUT  (64)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_operand(req_operand),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_h      (res_h),
      .res_l      (res_l),
      .res_err    (res_err),
      .busy       (busy),
      .m_sel      (m_sel),
      .m_wr       (m_wr),
      .m_addr     (m_addr),
      .m_dout     (m_dout),
      .m_din      (m_din),
      .irq        (irq)
   );

   // ---------------- slave model ----------------
   function automatic logic [127:0] fact(input logic [63:0] n);
      logic [127:0] r;
      r = 128'd1;
      for (int k = 2; k <= int'(n); k++) r = r * 128'(k);
      return r;
   endfunction

   logic [63:0]  s_opnd;
   logic         s_done, s_run, s_ien;
   int           s_cnt;
   logic [127:0] s_res;
   bit           never_done = 0;
   int           lat = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_opnd <= '0; s_done <= 0; s_run <= 0; s_ien <= 0;
         s_cnt <= 0; s_res <= '0;
      end else begin
         if (s_run) begin
            if (s_cnt == 0) begin
               s_run <= 0;
               if (!never_done) s_done <= 1;
            end else s_cnt <= s_cnt - 1;
         end
         if (m_sel && m_wr) begin
            case (m_addr)
               16'h0020: s_opnd <= m_dout;
               16'h0000: if (m_dout[0]) begin
                  s_run <= 1; s_cnt <= lat; s_res <= fact(s_opnd);
               end
               16'h0008: if (m_dout[0]) begin
                  s_done <= 0; s_run <= 0;
               end
               16'h0018: s_ien <= m_dout[0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      m_din = 64'd0;
      if (m_sel && !m_wr) begin
         case (m_addr)
            16'h0010: m_din = {63'd0, s_done};
            16'h0028: m_din = s_res[127:64];
            16'h0030: m_din = s_res[63:0];
            default:  m_din = 64'd0;
         endcase
      end
   end
   assign irq = s_done & s_ien;

   // ---------------- bus trace ----------------
   typedef struct {
      int          cyc;
      bit          wr;
      logic [15:0] addr;
      logic [63:0] data;
   } tr_t;
   tr_t trace[$];

   always @(posedge clk)
      if (m_sel) trace.push_back('{cyc, m_wr, m_addr, m_wr ? m_dout : m_din});

   function automatic bit ent(input int i, input bit wr,
                              input logic [15:0] a, input logic [63:0] d);
      if (i < 0 || i >= trace.size()) return 0;
      return trace[i].wr == wr && trace[i].addr == a && trace[i].data == d;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [63:0] opnd;
      int          lat;
      bit          never;
      int          hold;
      int          polls;
      int          rlat;
      logic [63:0] eh;
      logic [63:0] el;
      bit          eerr;
      bit          exact;
   } vec_t;

   task automatic run_op(input vec_t v);
      int base, t, st, rv, acc, n, i, np, nrd;
      bit ok;
      never_done = v.never;
      lat = v.lat;
      base = trace.size();
      @(negedge clk);
      acc = cyc;
      req_operand = v.opnd;
      req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      req_operand = 64'd0;
      t = 0;
      while (!res_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("res_valid_seen", res_valid, 1);
      rv = cyc;
      st = -1;
      for (int k = base; k < trace.size(); k++)
         if (st < 0 && trace[k].wr && trace[k].addr == 16'h0000) st = trace[k].cyc;
      chk("res_h", res_h, v.eh);
      chk("res_l", res_l, v.el);
      chk("res_err", res_err, v.eerr);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
`ifdef FACTO_MASTER_IRQ_EN
      chk("start_cyc", st, acc + 3);
`else
      chk("start_cyc", st, acc + 2);
      if (v.rlat >= 0) chk("accept_to_valid", rv - acc, v.rlat);
`endif
      if (v.never) begin
         chk("tmo_lat_max", (rv - st) <= 64 + 4 + 4, 1);
         chk("tmo_lat_min", (rv - st) >= 64, 1);
      end
      n = trace.size();
      for (int k = 0; k < v.hold; k++) begin
         req_valid = (k == 3);
         req_operand = (k == 3) ? 64'd2 : 64'd0;
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_h", res_h, v.eh);
         chk("hold_l", res_l, v.el);
         chk("hold_err", res_err, v.eerr);
         chk("hold_req_ready", req_ready, 0);
      end
      req_valid = 0;
      req_operand = 64'd0;
      chk("hold_no_bus", trace.size(), n);
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
      chk("idle_req_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_res_valid", res_valid, 0);
      ok = ent(trace.size() - 2, 1, 16'h0008, 64'd1) &&
           ent(trace.size() - 1, 1, 16'h0008, 64'd0);
      chk("clear_seq", ok, 1);
      nrd = 0;
      np = 0;
      for (int k = base; k < trace.size(); k++) begin
         if (!trace[k].wr && trace[k].addr == 16'h0028) nrd++;
         if (!trace[k].wr && trace[k].addr == 16'h0010) np++;
      end
      chk("rd_h_count", nrd, v.never ? 0 : 1);
`ifdef FACTO_MASTER_IRQ_EN
      chk("no_polls", np, 0);
`else
      if (v.polls >= 0) chk("poll_count", np, v.polls);
`endif
      if (v.exact) begin
         i = base;
         ok = ent(i, 1, 16'h0020, v.opnd);
         chk("opnd_wr_cyc", trace[i].cyc, acc + 1);
         i++;
`ifdef FACTO_MASTER_IRQ_EN
         ok &= ent(i, 1, 16'h0018, 64'd1);
         i++;
`endif
         ok &= ent(i, 1, 16'h0000, 64'd1);
         i++;
`ifndef FACTO_MASTER_IRQ_EN
         if (i < trace.size()) chk("first_poll_cyc", trace[i].cyc, st + 5);
`endif
         while (i < trace.size() && !trace[i].wr && trace[i].addr == 16'h0010) i++;
         ok &= ent(i, 0, 16'h0028, v.eh);
         i++;
         ok &= ent(i, 0, 16'h0030, v.el);
         i++;
         ok &= ent(i, 1, 16'h0008, 64'd1);
         i++;
         ok &= ent(i, 1, 16'h0008, 64'd0);
         i++;
         ok &= (i == trace.size());
         chk("trace_exact", ok, 1);
      end
   endtask

   vec_t vt[7];
   vec_t vr;
   int   t;

   initial begin
      vt[0] = '{64'd5,  20, 1'b0, 0,  5, -1, 64'd0, 64'd120, 1'b0, 1'b1};
      vt[1] = '{64'd0,   0, 1'b0, 0,  1, 12, 64'd0, 64'd1,   1'b0, 1'b0};
      vt[2] = '{64'd1,   3, 1'b0, 0, -1, -1, 64'd0, 64'd1,   1'b0, 1'b0};
      vt[3] = '{64'd20, 30, 1'b0, 0,  7, -1, 64'd0,
                64'h21C3_677C_82B4_0000, 1'b0, 1'b0};
      vt[4] = '{64'd21,  7, 1'b0, 0, -1, -1, 64'd2,
                64'hC507_7D36_B8C4_0000, 1'b0, 1'b0};
      vt[5] = '{64'd6,  12, 1'b0, 10, -1, -1, 64'd0, 64'd720, 1'b0, 1'b0};
      vt[6] = '{64'd9,   0, 1'b1, 0, -1, -1, 64'd0, 64'd0,   1'b1, 1'b0};
      vr    = '{64'd4,  20, 1'b0, 0, -1, -1, 64'd0, 64'd24,  1'b0, 1'b0};

      #1 reset_n = 0;
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_bus", {m_sel, m_wr, m_addr, m_dout}, 0);
      chk("rst_res", {res_err, res_h, res_l}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1;
      @(negedge clk);

      for (int k = 0; k < 7; k++) run_op(vt[k]);

      never_done = 0;
      lat = 20;
      @(negedge clk);
      req_operand = 64'd4;
      req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      req_operand = 64'd0;
      repeat (3) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      chk("pre_reset_no_valid", res_valid, 0);
      #2 reset_n = 0;
      #1;
      chk("arst_req_ready", req_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_bus", {m_sel, m_wr, m_addr, m_dout}, 0);
      chk("arst_res", {res_valid, res_err, res_h, res_l}, 0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      chk("post_reset_idle", req_ready, 1);
      run_op(vr);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
